// File: rtl/wb_axis_bridge_if.sv
// Bus bundle for wb_axis_bridge: Wishbone classic slave port plus NUM_CH
// AXI-Stream channel pairs (ss_* toward accelerators, sm_* back from them).
interface wb_axis_bridge_if #(
  parameter int NUM_CH = 3
);
  logic                    wbs_cyc_i;
  logic                    wbs_stb_i;
  logic                    wbs_we_i;
  logic [3:0]              wbs_sel_i;
  logic [31:0]             wbs_adr_i;
  logic [31:0]             wbs_dat_i;
  logic                    wbs_ack_o;
  logic [31:0]             wbs_dat_o;
  logic [NUM_CH-1:0]       ss_tvalid;
  logic [32*NUM_CH-1:0]    ss_tdata;
  logic [NUM_CH-1:0]       ss_tlast;
  logic [NUM_CH-1:0]       ss_tready;
  logic [NUM_CH-1:0]       sm_tvalid;
  logic [32*NUM_CH-1:0]    sm_tdata;
  logic [NUM_CH-1:0]       sm_tlast;
  logic [NUM_CH-1:0]       sm_tready;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output ss_tvalid, ss_tdata, ss_tlast,
    input  ss_tready,
    input  sm_tvalid, sm_tdata, sm_tlast,
    output sm_tready
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  ss_tvalid, ss_tdata, ss_tlast,
    output ss_tready,
    output sm_tvalid, sm_tdata, sm_tlast,
    input  sm_tready
  );
endinterface

// File: rtl/wb_axis_bridge.sv
// Wishbone slave to NUM_CH AXI-Stream channels: one bus transaction at a time,
// per-channel result FIFOs, and bounded waits so every access is acked.
module wb_axis_bridge #(
  parameter int          NUM_CH     = 3,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [11:0] BASE_HI    = 12'h300,
  parameter int          TIMEOUT    = 255
) (
  input  logic             axis_clk,
  input  logic             axis_rst_n,
  wb_axis_bridge_if.slave  bus
);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [15:0]   TMO  = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE = 2'd0, PUSH = 2'd1, POP = 2'd2, ACK = 2'd3} state_t;

  state_t                 state_r, state_s;
  logic                   skip_r;
  logic [CHW-1:0]         ch_r;
  logic [15:0]            wait_r;
  logic                   ack_r;
  logic [31:0]            dat_r;
  logic [NUM_CH-1:0]      valid_r, tlast_r;
  logic [32*NUM_CH-1:0]   tdata_r;
  logic [NUM_CH-1:0]      ovf_r, unf_r, seen_r;
  logic [32:0]            mem_r [NUM_CH][FIFO_DEPTH];
  logic [AW-1:0]          wptr_r [NUM_CH];
  logic [AW-1:0]          rptr_r [NUM_CH];
  logic [CW-1:0]          count_r [NUM_CH];

  logic [3:0]             ch_in_s;
  logic [CHW-1:0]         ch_idx_s;
  logic [1:0]             reg_s;
  logic                   sel_s, in_range_s, accept_s, status_rd_s;
  logic [32:0]            head_s;
  logic [31:0]            status_s, rd_s;
  logic                   push_to_s, pop_ok_s, pop_to_s;
  logic [NUM_CH-1:0]      sm_ready_s, push_s, pop_s, onehot_s;
  logic                   unused_s;

  assign ch_in_s    = bus.wbs_adr_i[11:8];
  assign ch_idx_s   = ch_in_s[CHW-1:0];
  assign reg_s      = bus.wbs_adr_i[3:2];
  assign sel_s      = bus.wbs_cyc_i & bus.wbs_stb_i & (|bus.wbs_sel_i) &
                      (bus.wbs_adr_i[31:20] == BASE_HI) & bus.wbs_adr_i[7];
  assign in_range_s = ({1'b0, ch_in_s} < 5'(NUM_CH));
  assign accept_s   = (state_r == IDLE) & ~skip_r & sel_s;
  assign status_rd_s = accept_s & in_range_s & ~bus.wbs_we_i & (reg_s == 2'd1);
  assign onehot_s   = NUM_CH'(1) << ch_idx_s;
  assign head_s     = mem_r[ch_r][rptr_r[ch_r]];
  assign status_s   = {ovf_r[ch_idx_s], unf_r[ch_idx_s], seen_r[ch_idx_s],
                       bus.ss_tready[ch_idx_s], 12'd0, 16'(count_r[ch_idx_s])};
  assign unused_s   = ^{bus.wbs_adr_i[19:12], bus.wbs_adr_i[6:4], bus.wbs_adr_i[1:0]};

  assign bus.wbs_ack_o = ack_r;
  assign bus.wbs_dat_o = dat_r;
  assign bus.ss_tvalid = valid_r;
  assign bus.ss_tdata  = tdata_r;
  assign bus.ss_tlast  = tlast_r;
  assign bus.sm_tready = sm_ready_s;

  // FIFO handshake decode per channel
  always_comb begin
    sm_ready_s = '0;
    push_s     = '0;
    pop_s      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sm_ready_s[i] = (count_r[i] != FULL);
      push_s[i]     = bus.sm_tvalid[i] & sm_ready_s[i];
      pop_s[i]      = pop_ok_s & (ch_r == CHW'(i));
    end
  end

  // FSM state register
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state and transaction outcomes
  always_comb begin
    state_s   = state_r;
    push_to_s = 1'b0;
    pop_ok_s  = 1'b0;
    pop_to_s  = 1'b0;
    rd_s      = 32'd0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (!in_range_s) begin
            state_s = ACK;
          end else if (bus.wbs_we_i && !reg_s[1]) begin
            state_s = PUSH;
          end else if (!bus.wbs_we_i && (reg_s == 2'd0)) begin
            state_s = POP;
          end else begin
            state_s = ACK;
            if (status_rd_s) begin
              rd_s = status_s;
            end else begin
              rd_s = 32'd0;
            end
          end
        end else begin
          state_s = IDLE;
        end
      end
      PUSH: begin
        if (bus.ss_tready[ch_r]) begin
          state_s = ACK;
        end else if (wait_r == TMO) begin
          state_s   = ACK;
          push_to_s = 1'b1;
        end else begin
          state_s = PUSH;
        end
      end
      POP: begin
        if (count_r[ch_r] != '0) begin
          state_s  = ACK;
          pop_ok_s = 1'b1;
          rd_s     = head_s[31:0];
        end else if (wait_r == TMO) begin
          state_s  = ACK;
          pop_to_s = 1'b1;
        end else begin
          state_s = POP;
        end
      end
      ACK:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Transaction datapath: ack/read data, stream outputs, wait counter, sticky flags
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      skip_r  <= 1'b0;
      ch_r    <= '0;
      wait_r  <= 16'd0;
      ack_r   <= 1'b0;
      dat_r   <= 32'd0;
      valid_r <= '0;
      tlast_r <= '0;
      tdata_r <= '0;
      ovf_r   <= '0;
      unf_r   <= '0;
      seen_r  <= '0;
    end else begin
      skip_r <= (state_r == ACK);
      ack_r  <= (state_s == ACK);
      if (accept_s) begin
        ch_r <= ch_idx_s;
      end
      if ((state_r == PUSH) || (state_r == POP)) begin
        wait_r <= wait_r + 16'd1;
      end else begin
        wait_r <= 16'd0;
      end
      if ((state_s == ACK) && (state_r != ACK)) begin
        dat_r <= rd_s;
      end
      // Beat launches on request acceptance and holds until handshake or timeout
      if (accept_s && (state_s == PUSH)) begin
        valid_r <= onehot_s;
        tlast_r <= (reg_s == 2'd1) ? onehot_s : '0;
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_idx_s == CHW'(i)) begin
            tdata_r[32*i +: 32] <= bus.wbs_dat_i;
          end
        end
      end else if ((state_r == PUSH) && (state_s != PUSH)) begin
        valid_r <= '0;
        tlast_r <= '0;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (status_rd_s && (ch_idx_s == CHW'(i))) begin
          ovf_r[i]  <= 1'b0;
          unf_r[i]  <= 1'b0;
          seen_r[i] <= 1'b0;
        end else begin
          if (push_to_s && (ch_r == CHW'(i))) ovf_r[i] <= 1'b1;
          if (pop_to_s && (ch_r == CHW'(i)))  unf_r[i] <= 1'b1;
          if (pop_s[i] && head_s[32])         seen_r[i] <= 1'b1;
        end
      end
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wptr_r[i]  <= '0;
        rptr_r[i]  <= '0;
        count_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push_s[i]) wptr_r[i] <= wptr_r[i] + AW'(1);
        if (pop_s[i])  rptr_r[i] <= rptr_r[i] + AW'(1);
        case ({push_s[i], pop_s[i]})
          2'b10:   count_r[i] <= count_r[i] + CW'(1);
          2'b01:   count_r[i] <= count_r[i] - CW'(1);
          default: count_r[i] <= count_r[i];
        endcase
      end
    end
  end

  // FIFO storage; contents are don't-care while empty so no reset is needed
  always_ff @(posedge axis_clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push_s[i]) begin
        mem_r[i][wptr_r[i]] <= {bus.sm_tlast[i], bus.sm_tdata[32*i +: 32]};
      end
    end
  end
endmodule

// File: tb/tb_wb_axis_bridge.sv
// Directed self-checking bench for wb_axis_bridge (NUM_CH=3, FIFO_DEPTH=8, TIMEOUT=255).
module tb_wb_axis_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic [2:0]  seen_valid;
  logic [2:0]  seen_last;
  logic [95:0] seen_data;
  int          vcnt;

  wb_axis_bridge_if #(.NUM_CH(3)) bus ();

  wb_axis_bridge #(
    .NUM_CH(3), .FIFO_DEPTH(8), .BASE_HI(12'h300), .TIMEOUT(255)
  ) dut (
    .axis_clk(clk),
    .axis_rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                         output logic [31:0] rdat, output int lat);
    logic got;
    @(negedge clk);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = adr; bus.wbs_dat_i = wdat;
    lat = 0; rdat = 32'd0; got = 1'b0;
    vcnt = 0; seen_valid = 3'b000; seen_last = 3'b000; seen_data = '0;
    while (!got && lat < 400) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (bus.ss_tvalid != 3'b000) begin
        vcnt++;
        seen_valid = seen_valid | bus.ss_tvalid;
        seen_last  = seen_last | bus.ss_tlast;
        seen_data  = bus.ss_tdata;
      end
      if (bus.wbs_ack_o) begin
        got  = 1'b1;
        rdat = bus.wbs_dat_o;
      end
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    total++;
    if (!got) begin
      bad++;
      $display("FAIL ack_wait adr=%h: no ack within %0d cycles", adr, lat);
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    int lat;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.wbs_ack_o !== 1'b0) begin bad++; $display("FAIL rst_ack got %b want 0", bus.wbs_ack_o); end
    total++; if (bus.wbs_dat_o !== 32'd0) begin bad++; $display("FAIL rst_dat got %h want 0", bus.wbs_dat_o); end
    total++; if (bus.ss_tvalid !== 3'b000) begin bad++; $display("FAIL rst_valid got %b want 000", bus.ss_tvalid); end
    total++; if (bus.sm_tready !== 3'b111) begin bad++; $display("FAIL rst_smready got %b want 111", bus.sm_tready); end
    rst_n = 1'b1;
    // start a push that cannot complete, then reset it mid-flight
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
    bus.wbs_sel_i = 4'hF; bus.wbs_adr_i = 32'h3000_0080; bus.wbs_dat_i = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    total++; if (bus.ss_tvalid !== 3'b001) begin bad++; $display("FAIL midpush_valid got %b want 001", bus.ss_tvalid); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.ss_tvalid !== 3'b000) begin bad++; $display("FAIL rst_drop_valid got %b want 000", bus.ss_tvalid); end
    total++; if (bus.wbs_ack_o !== 1'b0) begin bad++; $display("FAIL rst_drop_ack got %b want 0", bus.wbs_ack_o); end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.ss_tready = 3'b111;
    wb_xfer(1'b0, 32'h3000_0084, 32'd0, r, lat);
    total++; if (r !== 32'h1000_0000) begin bad++; $display("FAIL rst_status got %h want 10000000", r); end
    total++; if (lat != 1) begin bad++; $display("FAIL status_lat got %0d want 1", lat); end
    total++; if (bus.sm_tready !== 3'b111) begin bad++; $display("FAIL post_rst_smready got %b want 111", bus.sm_tready); end
  endtask

  task automatic test_push();
    logic [31:0] r;
    int lat;
    bus.ss_tready = 3'b111;
    wb_xfer(1'b1, 32'h3000_0080, 32'h0000_1234, r, lat);
    total++; if (lat != 2) begin bad++; $display("FAIL push_lat got %0d want 2", lat); end
    total++; if (vcnt != 1) begin bad++; $display("FAIL push_vcnt got %0d want 1", vcnt); end
    total++; if (seen_valid !== 3'b001) begin bad++; $display("FAIL push_valid got %b want 001", seen_valid); end
    total++; if (seen_data[31:0] !== 32'h0000_1234) begin bad++; $display("FAIL push_data got %h want 00001234", seen_data[31:0]); end
    total++; if (seen_last !== 3'b000) begin bad++; $display("FAIL push_last got %b want 000", seen_last); end
    wb_xfer(1'b1, 32'h3000_0184, 32'hCAFE_F00D, r, lat);
    total++; if (lat != 2) begin bad++; $display("FAIL last_lat got %0d want 2", lat); end
    total++; if (seen_valid !== 3'b010) begin bad++; $display("FAIL last_valid got %b want 010", seen_valid); end
    total++; if (seen_last !== 3'b010) begin bad++; $display("FAIL last_flag got %b want 010", seen_last); end
    total++; if (seen_data[63:32] !== 32'hCAFE_F00D) begin bad++; $display("FAIL last_data got %h want cafef00d", seen_data[63:32]); end
  endtask

  task automatic test_fifo_fill();
    logic [31:0] r;
    int lat;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 7) begin
        total++; if (bus.sm_tready[2] !== 1'b1) begin bad++; $display("FAIL fill7_ready got %b want 1", bus.sm_tready[2]); end
      end
      bus.sm_tvalid = 3'b100;
      bus.sm_tlast  = 3'b000;
      bus.sm_tdata[64 +: 32] = 32'h100 + 32'(k);
    end
    @(negedge clk);
    total++; if (bus.sm_tready[2] !== 1'b0) begin bad++; $display("FAIL full_ready got %b want 0", bus.sm_tready[2]); end
    bus.sm_tdata[64 +: 32] = 32'h108;
    bus.sm_tlast = 3'b100;
    @(negedge clk);
    total++; if (bus.sm_tready[2] !== 1'b0) begin bad++; $display("FAIL full_hold got %b want 0", bus.sm_tready[2]); end
    wb_xfer(1'b0, 32'h3000_0284, 32'd0, r, lat);
    total++; if (r !== 32'h1000_0008) begin bad++; $display("FAIL full_status got %h want 10000008", r); end
    wb_xfer(1'b0, 32'h3000_0280, 32'd0, r, lat);
    total++; if (r !== 32'h0000_0100) begin bad++; $display("FAIL pop0 got %h want 00000100", r); end
    total++; if (lat != 2) begin bad++; $display("FAIL pop_lat got %0d want 2", lat); end
    total++; if (bus.sm_tready[2] !== 1'b1) begin bad++; $display("FAIL ready_after_pop got %b want 1", bus.sm_tready[2]); end
    @(posedge clk);
    @(negedge clk);
    bus.sm_tvalid = 3'b000;
    bus.sm_tlast  = 3'b000;
    for (int k = 1; k < 9; k++) begin
      wb_xfer(1'b0, 32'h3000_0280, 32'd0, r, lat);
      total++; if (r !== 32'h100 + 32'(k)) begin bad++; $display("FAIL pop%0d got %h want %h", k, r, 32'h100 + 32'(k)); end
    end
    wb_xfer(1'b0, 32'h3000_0284, 32'd0, r, lat);
    total++; if (r !== 32'h3000_0000) begin bad++; $display("FAIL seen_status got %h want 30000000", r); end
    wb_xfer(1'b0, 32'h3000_0284, 32'd0, r, lat);
    total++; if (r !== 32'h1000_0000) begin bad++; $display("FAIL seen_clear got %h want 10000000", r); end
  endtask

  task automatic test_pop_timeout();
    logic [31:0] r;
    int lat;
    wb_xfer(1'b0, 32'h3000_0084, 32'd0, r, lat);
    wb_xfer(1'b0, 32'h3000_0180, 32'd0, r, lat);
    total++; if (lat != 257) begin bad++; $display("FAIL poptmo_lat got %0d want 257", lat); end
    total++; if (r !== 32'd0) begin bad++; $display("FAIL poptmo_data got %h want 0", r); end
    wb_xfer(1'b0, 32'h3000_0184, 32'd0, r, lat);
    total++; if (r !== 32'h5000_0000) begin bad++; $display("FAIL unf_status got %h want 50000000", r); end
    wb_xfer(1'b0, 32'h3000_0184, 32'd0, r, lat);
    total++; if (r !== 32'h1000_0000) begin bad++; $display("FAIL unf_clear got %h want 10000000", r); end
  endtask

  task automatic test_push_timeout();
    logic [31:0] r;
    int lat;
    bus.ss_tready = 3'b110;
    wb_xfer(1'b1, 32'h3000_0080, 32'h0000_5555, r, lat);
    total++; if (lat != 257) begin bad++; $display("FAIL pushtmo_lat got %0d want 257", lat); end
    total++; if (vcnt != 256) begin bad++; $display("FAIL pushtmo_vcnt got %0d want 256", vcnt); end
    wb_xfer(1'b0, 32'h3000_0084, 32'd0, r, lat);
    total++; if (r !== 32'h8000_0000) begin bad++; $display("FAIL ovf_status got %h want 80000000", r); end
    wb_xfer(1'b0, 32'h3000_0184, 32'd0, r, lat);
    total++; if (r !== 32'h1000_0000) begin bad++; $display("FAIL ovf_other got %h want 10000000", r); end
    wb_xfer(1'b0, 32'h3000_0084, 32'd0, r, lat);
    total++; if (r !== 32'h0000_0000) begin bad++; $display("FAIL ovf_clear got %h want 00000000", r); end
    bus.ss_tready = 3'b111;
  endtask

  task automatic test_out_of_range();
    logic [31:0] r;
    int lat;
    wb_xfer(1'b0, 32'h3000_0084, 32'd0, r, lat);
    total++; if (r !== 32'h1000_0000) begin bad++; $display("FAIL pre_oor_status got %h want 10000000", r); end
    wb_xfer(1'b0, 32'h3000_0F80, 32'd0, r, lat);
    total++; if (lat != 1) begin bad++; $display("FAIL oor_lat got %0d want 1", lat); end
    total++; if (r !== 32'd0) begin bad++; $display("FAIL oor_data got %h want 0", r); end
    wb_xfer(1'b1, 32'h3000_0F80, 32'h1111_2222, r, lat);
    total++; if (seen_valid !== 3'b000) begin bad++; $display("FAIL oor_valid got %b want 000", seen_valid); end
    total++; if (lat != 1) begin bad++; $display("FAIL oorw_lat got %0d want 1", lat); end
    wb_xfer(1'b0, 32'h3000_0084, 32'd0, r, lat);
    wb_xfer(1'b0, 32'h3000_0088, 32'd0, r, lat);
    total++; if (r !== 32'd0) begin bad++; $display("FAIL rsvd_data got %h want 0", r); end
    total++; if (lat != 1) begin bad++; $display("FAIL rsvd_lat got %0d want 1", lat); end
    wb_xfer(1'b1, 32'h3000_008C, 32'h7777_7777, r, lat);
    total++; if (seen_valid !== 3'b000) begin bad++; $display("FAIL rsvdw_valid got %b want 000", seen_valid); end
  endtask

  initial begin
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'd0; bus.wbs_dat_i = 32'd0;
    bus.ss_tready = 3'b000; bus.sm_tvalid = 3'b000; bus.sm_tlast = 3'b000;
    bus.sm_tdata  = '0;
    test_reset();
    test_push();
    test_fifo_fill();
    test_pop_timeout();
    test_push_timeout();
    test_out_of_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_axis_bridge.md
# wb_axis_bridge

Parametrised Wishbone-slave to multi-channel AXI-Stream bridge for the user project area. It decodes CPU Wishbone accesses into NUM_CH independent stream accelerator channels (FIR, matmul, qsort, …). Each channel gets a handshaked input beat path and a per-channel output FIFO that absorbs accelerator results, replacing fixed-delay tready pulsing. Bounded-wait timeouts guarantee the bus always receives an ack.

## Interface
Parameters:
- NUM_CH, 3, number of stream channels (1–16)
- FIFO_DEPTH, 8, output FIFO depth per channel (power of 2, ≥2)
- BASE_HI, 12'h300, required value of wbs_adr_i[31:20]
- TIMEOUT, 255, maximum wait cycles for ss_tready or FIFO data (1–65535)

Ports:
- axis_clk  in  1  single clock for all logic
- axis_rst_n  in  1  asynchronous, active-low reset
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic controls
- wbs_sel_i  in  4  byte selects (any nonzero = access; partial writes send the full word)
- wbs_adr_i  in  32  address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  registered single-cycle ack
- wbs_dat_o  out  32  registered read data, valid with ack
- ss_tvalid  out  NUM_CH  per-channel input beat valid
- ss_tdata  out  32*NUM_CH  channel i at [32i+31:32i]
- ss_tlast  out  NUM_CH  per-channel last flag
- ss_tready  in  NUM_CH  accelerator accepts beat
- sm_tvalid  in  NUM_CH  accelerator result valid
- sm_tdata  in  32*NUM_CH  result data, packed as ss_tdata
- sm_tlast  in  NUM_CH  result last flag
- sm_tready  out  NUM_CH  = FIFO i not full (combinational)

## Operation
- Selected: cyc & stb & |sel & adr[31:20]==BASE_HI & adr[7]==1. Channel ch = adr[11:8]; register = adr[3:2].
- Registers per channel: 0x80 DATA (write: beat tlast=0; read: pop FIFO), 0x84 LAST (write: beat tlast=1; read: status), 0x88/0x8C reserved (read 0, writes ignored, ack in 1 cycle).
- ch ≥ NUM_CH: ack in 1 cycle, read data 0, write dropped, no side effects.
- Status word: [31] ovf sticky (push timeout), [30] unf sticky (pop timeout), [29] last_seen sticky (popped beat had tlast), [28] live ss_tready[ch], [27:16] 0, [15:0] FIFO count. Status read returns then clears [31:29] of that channel only.
- FIFO: 33-bit entries {last,data}; write when sm_tvalid[i] & sm_tready[i]; count 0..FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH. Simultaneous capture and pop: count unchanged.
- FSM (one transaction at a time):
  - IDLE: on selected access go PUSH (DATA/LAST write), POP (DATA read) or ACK (all else); capture ch, data, tlast, reset wait counter.
  - PUSH: ss_tvalid[ch]=1, ss_tdata/ss_tlast stable. ss_tready[ch] → ACK. Counter reaching TIMEOUT → drop beat, set ovf, ACK.
  - POP: FIFO[ch] non-empty → latch head into wbs_dat_o, pop, set last_seen if entry last, ACK. Counter reaching TIMEOUT → wbs_dat_o=0, set unf, ACK.
  - ACK: wbs_ack_o=1 for exactly this cycle; → IDLE. IDLE ignores bus in the cycle following ACK.
- Only channel ch drives ss_tvalid; all others 0.

## Timing
- Reset (async assert, sync-safe release): state IDLE, wbs_ack_o=0, wbs_dat_o=0, ss_tvalid=0, ss_tlast=0, ss_tdata=0, FIFOs empty (sm_tready all 1), sticky bits 0, counters 0.
- Reset mid-transaction: abandon, no ack, queued FIFO data lost.
- Status/reserved/out-of-range access: ack 1 cycle after the request edge.
- Push with ss_tready already high: ss_tvalid 1 cycle after request, ack the following cycle (2-cycle latency).
- Pop from non-empty FIFO: ack and data 2 cycles after request.
- Timeout: ack exactly TIMEOUT+2 cycles after request when no handshake/data.
- Beat arriving in FIFO the same cycle POP samples empty is taken next cycle.
- Full FIFO: sm_tready low same cycle count reaches FIFO_DEPTH; rises the cycle after a pop.

## Test plan
- Reset: assert axis_rst_n=0 mid-PUSH → ss_tvalid, wbs_ack_o drop immediately; after release sm_tready=3'b111, status reads 0x1000_0000 with ss_tready=1.
- Push: write 0x3000_0080 data 0x1234 with ss_tready[0]=1 → ss_tdata[31:0]=0x1234, ss_tlast=0 one cycle, ack 2 cycles after request; write 0x3000_0184 → ss_tlast[1]=1.
- FIFO fill: drive 9 results on channel 2 (FIFO_DEPTH=8) → sm_tready[2]=0 after 8th, status count=8; 8 reads of 0x3000_0280 return order 0..7, 9th accepted after first pop.
- Pop timeout: read empty channel 1 DATA → ack at cycle 257, data 0; status reads bit30=1, second status read bit30=0.
- Push timeout: ss_tready[0]=0, write DATA → ack at cycle 257, no beat, ovf set; other channels' bits unaffected.
- Out-of-range: read 0x3000_0F80 with NUM_CH=3 → ack in 1 cycle, data 0, no ss_tvalid.
